// File: rtl/div_pkg.sv
// Shared types and constants for the unsigned restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

endpackage

// File: rtl/unsigned_restoring_divider_if.sv
// Request/result bundle between a requester and the divider.
interface unsigned_restoring_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             rdy;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, rdy, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, rdy, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/div_sub.sv
// (W+1)-bit subtractor using the ALU carry convention: borrow = ~carry(a + ~b + 1).
module div_sub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    assign diff   = sum[N-1:0];
    assign borrow = ~sum[N];
endmodule

// File: rtl/unsigned_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Quotient feeds LO and remainder feeds HI for DIVU-class instructions.
module unsigned_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    unsigned_restoring_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{DIV_ZERO_QUOTIENT[0]}};

    div_state_e         state;
    logic [2*WIDTH:0]   rq;
    logic [WIDTH-1:0]   dreg;
    logic [CNT_W-1:0]   cnt;
    logic               dbz;

    logic [2*WIDTH:0]   s;
    logic [WIDTH:0]     diff;
    logic               borrow;
    logic [2*WIDTH:0]   rq_next;

    assign s = rq << 1;

    div_sub #(.N(WIDTH + 1)) u_sub (
        .a      (s[2*WIDTH:WIDTH]),
        .b      ({1'b0, dreg}),
        .diff   (diff),
        .borrow (borrow)
    );

    // On a successful subtract the new quotient bit lands in the vacated LSB.
    assign rq_next = borrow ? s : {diff, s[WIDTH-1:1], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rq    <= '0;
            dreg  <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            // Result is preloaded so DONE reads it straight out of rq.
                            state <= DONE;
                            dbz   <= 1'b1;
                            rq    <= {1'b0, bus.dividend, ZERO_Q};
                        end else begin
                            state <= RUN;
                            dbz   <= 1'b0;
                            rq    <= {{(WIDTH + 1){1'b0}}, bus.dividend};
                            dreg  <= bus.divisor;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    rq  <= rq_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.rdy         = (state == DONE);
    assign bus.div_by_zero = dbz;
    assign bus.quotient    = rq[WIDTH-1:0];
    assign bus.remainder   = rq[2*WIDTH-1:WIDTH];
endmodule

// File: tb/tb_unsigned_restoring_divider.sv
// Scoreboard bench: driver pushes expected results, monitor pops on each completion.
module tb_unsigned_restoring_divider;
    import div_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           busy_cycles;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    unsigned_restoring_divider_if #(.WIDTH(W)) dif ();

    unsigned_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: a completion is rdy rising out of RUN or straight out of an accepting edge.
    int run_cnt = 0;
    always @(posedge clk) begin
        logic acc, was_busy;
        exp_t e;
        acc      = dif.start && !dif.busy && !rst;
        was_busy = dif.busy;
        #1;
        if (rst) begin
            run_cnt = 0;
        end else begin
            if (acc) run_cnt = 0;
            if (dif.busy) run_cnt++;
            if (dif.rdy && (acc || was_busy)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got q=0x%08h expected no result", dif.quotient);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, ".quotient"},    dif.quotient,       e.q);
                    check({e.name, ".remainder"},   dif.remainder,      e.r);
                    check({e.name, ".div_by_zero"}, W'(dif.div_by_zero), W'(e.z));
                    check({e.name, ".busy_cycles"}, W'(run_cnt),        W'(e.busy_cycles));
                    check({e.name, ".busy_rdy_excl"}, W'(dif.busy),     '0);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (dif.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dif.busy) begin
            checks++;
            failures++;
            $display("FAIL wait_ready_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
    endtask

    task automatic issue(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic push);
        exp_t e;
        wait_ready();
        if (push) begin
            e.name = name; e.q = q; e.r = r; e.z = (dvs == '0);
            e.busy_cycles = (dvs == '0) ? 0 : W;
            exp_q.push_back(e);
        end
        dif.start    = 1'b1;
        dif.dividend = dvd;
        dif.divisor  = dvs;
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".busy"},        W'(dif.busy),        '0);
        check({name, ".rdy"},         W'(dif.rdy),         '0);
        check({name, ".div_by_zero"}, W'(dif.div_by_zero), '0);
        check({name, ".quotient"},    dif.quotient,        '0);
        check({name, ".remainder"},   dif.remainder,       '0);
    endtask

    initial begin
        int n;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        issue("d100_7",  32'd100,        32'd7,          32'd14,         32'd2, 1'b1);
        issue("dmax_1",  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0, 1'b1);
        issue("dmax_max",32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0, 1'b1);
        issue("d3_10",   32'd3,          32'd10,         32'd0,          32'd3, 1'b1);
        issue("d0_5",    32'd0,          32'd5,          32'd0,          32'd0, 1'b1);
        issue("d5_0",    32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5, 1'b1);
        issue("d0_0",    32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0, 1'b1);

        // start during RUN must be ignored
        issue("d1000_3", 32'd1000,       32'd3,          32'd333,        32'd1, 1'b1);
        repeat (9) @(negedge clk);
        dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd9;
        @(negedge clk);
        dif.start = 1'b0;
        // back-to-back from DONE
        issue("d81_9",   32'd81,         32'd9,          32'd9,          32'd0, 1'b1);

        // reset mid-RUN
        issue("abort",   32'd50,         32'd7,          32'd0,          32'd0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_run_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue("d77_8",   32'd77,         32'd8,          32'd9,          32'd5, 1'b1);

        n = 0;
        while ((exp_q.size() != 0 || dif.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
